ih_weight_fetcher: RTL and testbench

// Read-side sequencer for a weight memory (READ_BURST-wide, 1-cycle read latency, read data held when

---
 rtl/ih_weight_fetcher.sv | 121 ++++++++++++
 tb/tb_ih_weight_fetcher.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ih_weight_fetcher.sv
// ih_weight_fetcher: streams a row-major weight matrix from a 1-cycle-latency memory through a 2-entry FIFO
module ih_weight_fetcher #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_BURST = 1,
    parameter int NUM_ROWS   = 100,
    parameter int ROW_LEN    = 6,
    parameter int BASE_ADDR  = 0,
    localparam int BW = DATA_WIDTH * READ_BURST,
    localparam int RW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1,
    localparam int CW = ROW_LEN > 1 ? $clog2(ROW_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_input_Pointer,
    input  logic [BW-1:0]         mem_input_element,
    output logic [BW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RW-1:0]         out_row,
    output logic [CW-1:0]         out_col,
    output logic                  out_last_col,
    output logic                  out_last
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t          state;
    logic [RW-1:0]   rd_row, inf_row;
    logic [CW-1:0]   rd_col, inf_col;
    logic            inf, inf_lc, inf_l;
    logic [BW-1:0]   f_data [2];
    logic [RW-1:0]   f_row [2];
    logic [CW-1:0]   f_col [2];
    logic            f_lc [2], f_l [2];
    logic            wp, rp;
    logic [1:0]      cnt;
    logic            pop, push, issue_lc, issue_l;
    assign pop = out_valid & out_ready;
    assign push = inf;
    assign issue_lc = rd_col == CW'(ROW_LEN - READ_BURST);
    assign issue_l = issue_lc && rd_row == RW'(NUM_ROWS - 1);
    assign busy = state != IDLE;
    // Reads in flight plus buffered beats never exceed the FIFO depth, so no beat can be dropped.
    assign mem_read_enable = state == FETCH && !abort && ({1'b0, cnt} + {2'b0, inf} - {2'b0, pop}) < 3'd2;
    assign out_valid = cnt != 2'd0;
    assign out_data = f_data[rp];
    assign out_row = f_row[rp];
    assign out_col = f_col[rp];
    assign out_last_col = f_lc[rp];
    assign out_last = f_l[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done <= 1'b0;
            mem_input_Pointer <= ADDR_WIDTH'(BASE_ADDR);
            rd_row <= '0;
            rd_col <= '0;
            inf <= 1'b0;
            inf_row <= '0;
            inf_col <= '0;
            inf_lc <= 1'b0;
            inf_l <= 1'b0;
            wp <= 1'b0;
            rp <= 1'b0;
            cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                f_data[i] <= '0;
                f_row[i] <= '0;
                f_col[i] <= '0;
                f_lc[i] <= 1'b0;
                f_l[i] <= 1'b0;
            end
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                inf <= 1'b0;
                wp <= 1'b0;
                rp <= 1'b0;
                cnt <= 2'd0;
            end else begin
                inf <= mem_read_enable;
                if (mem_read_enable) begin
                    inf_row <= rd_row;
                    inf_col <= rd_col;
                    inf_lc <= issue_lc;
                    inf_l <= issue_l;
                    mem_input_Pointer <= mem_input_Pointer + ADDR_WIDTH'(READ_BURST);
                    rd_col <= issue_lc ? '0 : rd_col + CW'(READ_BURST);
                    rd_row <= issue_lc ? rd_row + RW'(1) : rd_row;
                end
                if (push) begin
                    f_data[wp] <= mem_input_element;
                    f_row[wp] <= inf_row;
                    f_col[wp] <= inf_col;
                    f_lc[wp] <= inf_lc;
                    f_l[wp] <= inf_l;
                    wp <= ~wp;
                end
                if (pop)
                    rp <= ~rp;
                cnt <= cnt + 2'(push) - 2'(pop);
                if (state == IDLE && start) begin
                    state <= FETCH;
                    mem_input_Pointer <= ADDR_WIDTH'(BASE_ADDR);
                    rd_row <= '0;
                    rd_col <= '0;
                end else if (state == FETCH && mem_read_enable && issue_l) begin
                    state <= DRAIN;
                end else if (state == DRAIN && !inf && cnt == 2'(pop)) begin
                    state <= IDLE;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ih_weight_fetcher.sv
// tb_ih_weight_fetcher: scoreboard bench for burst-1 and burst-2 fetchers over a 3x4 matrix
module tb_ih_weight_fetcher;
    logic        clk = 1'b0;
    logic        rst_n, start, abort, out_ready, start1, ready1;
    logic        busy, done, re, ov, olc, ol;
    logic        busy1, done1, re1, ov1, olc1, ol1;
    logic [9:0]  ptr, ptr1;
    logic [15:0] rdata, odata;
    logic [31:0] rdata1, odata1;
    logic [1:0]  orow, ocol, orow1, ocol1;
    int passed = 0, total = 0, cyc = 0;
    int pops0 = 0, reads0 = 0, dones0 = 0, last_pop0 = -10;
    int pops1 = 0, dones1 = 0, last_pop1 = -10;
    logic [49:0] q0 [$];
    logic [49:0] q1 [$];
    logic [49:0] held = '0;
    logic        stalled = 1'b0;
    int p0, d0, r0;

    always #5 clk = ~clk;

    ih_weight_fetcher #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .READ_BURST(1), .NUM_ROWS(3), .ROW_LEN(4), .BASE_ADDR(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .mem_read_enable(re), .mem_input_Pointer(ptr), .mem_input_element(rdata),
        .out_data(odata), .out_valid(ov), .out_ready(out_ready), .out_row(orow), .out_col(ocol),
        .out_last_col(olc), .out_last(ol));

    ih_weight_fetcher #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .READ_BURST(2), .NUM_ROWS(3), .ROW_LEN(4), .BASE_ADDR(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .busy(busy1), .done(done1),
        .mem_read_enable(re1), .mem_input_Pointer(ptr1), .mem_input_element(rdata1),
        .out_data(odata1), .out_valid(ov1), .out_ready(ready1), .out_row(orow1), .out_col(ocol1),
        .out_last_col(olc1), .out_last(ol1));

    // memory model: mem[a] = a, lowest address in the MSBs of a burst
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re) rdata <= 16'(ptr);
        if (re1) rdata1 <= {16'(ptr1), 16'(ptr1 + 10'd1)};
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp0();
        for (int i = 0; i < 12; i++)
            q0.push_back({32'(i), 8'(i / 4), 8'(i % 4), i % 4 == 3, i == 11});
    endtask

    task automatic wait_idle0();
        for (int i = 0; i < 200 && busy; i++) tick();
        chk("idle0", busy, 0);
        tick();
    endtask

    always @(negedge clk) begin
        if (re) reads0 <= reads0 + 1;
        if (stalled) chk("stable0", {32'(odata), 8'(orow), 8'(ocol), olc, ol}, held);
        stalled <= ov && !out_ready;
        held <= {32'(odata), 8'(orow), 8'(ocol), olc, ol};
        if (ov && out_ready) begin
            pops0 <= pops0 + 1;
            last_pop0 <= cyc;
            if (q0.size() == 0) chk("extra_beat0", 1, 0);
            else chk("beat0", {32'(odata), 8'(orow), 8'(ocol), olc, ol}, q0.pop_front());
        end
        if (done) begin
            dones0 <= dones0 + 1;
            chk("done_lat0", cyc, last_pop0 + 1);
        end
        if (ov1 && ready1) begin
            pops1 <= pops1 + 1;
            last_pop1 <= cyc;
            if (q1.size() == 0) chk("extra_beat1", 1, 0);
            else chk("beat1", {odata1, 8'(orow1), 8'(ocol1), olc1, ol1}, q1.pop_front());
        end
        if (done1) begin
            dones1 <= dones1 + 1;
            chk("done_lat1", cyc, last_pop1 + 1);
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; start1 = 1'b0; ready1 = 1'b1;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_re", re, 0);
        chk("rst_valid", ov, 0);
        chk("rst_data", odata, 0);
        chk("rst_ptr", ptr, 0);
        chk("rst_tags", {orow, ocol, olc, ol}, 0);
        chk("rst_busy1", busy1, 0);
        rst_n = 1'b1;
        tick();
        // back-to-back stream with latency checks
        d0 = dones0; r0 = reads0; p0 = pops0;
        push_exp0();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_e0_valid", ov, 0);
        chk("lat_e0_re", re, 1);
        tick();
        chk("lat_e1_valid", ov, 0);
        tick();
        chk("lat_e2_valid", ov, 1);
        wait_idle0();
        chk("t2_dones", dones0 - d0, 1);
        chk("t2_reads", reads0 - r0, 12);
        chk("t2_pops", pops0 - p0, 12);
        chk("t2_q", q0.size(), 0);
        // backpressure
        d0 = dones0; r0 = reads0; p0 = pops0;
        push_exp0();
        start = 1'b1;
        for (int c = 0; c < 80 && (c < 2 || busy); c++) begin
            tick();
            start = 1'b0;
            out_ready = !(c >= 3 && c <= 8) && (c <= 8 || c % 2 == 0);
            #1;
            if (c == 8) chk("t3_stall_re", re, 0);
        end
        out_ready = 1'b1;
        chk("idle3", busy, 0);
        tick();
        chk("t3_dones", dones0 - d0, 1);
        chk("t3_reads", reads0 - r0, 12);
        chk("t3_q", q0.size(), 0);
        // abort mid-stream, then restart
        d0 = dones0; p0 = pops0;
        push_exp0();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && pops0 - p0 < 6; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_valid", ov, 0);
        q0.delete();
        repeat (5) tick();
        chk("t5_no_done", dones0 - d0, 0);
        d0 = dones0; p0 = pops0;
        push_exp0();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle0();
        chk("t5_dones", dones0 - d0, 1);
        chk("t5_pops", pops0 - p0, 12);
        // start while busy is ignored
        d0 = dones0; p0 = pops0; r0 = reads0;
        push_exp0();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_busy", busy, 1);
        wait_idle0();
        repeat (3) tick();
        chk("t6_dones", dones0 - d0, 1);
        chk("t6_pops", pops0 - p0, 12);
        chk("t6_reads", reads0 - r0, 12);
        chk("t6_q", q0.size(), 0);
        // async reset mid-fetch
        push_exp0();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("t1_outs", {busy, done, re, ov, odata, orow, ocol, olc, ol}, 0);
        q0.delete();
        tick();
        rst_n = 1'b1;
        p0 = pops0;
        tick();
        chk("t1_busy", busy, 0);
        repeat (8) tick();
        chk("t1_no_beats", pops0 - p0, 0);
        // burst of two elements per beat
        for (int k = 0; k < 6; k++)
            q1.push_back({16'(2 * k), 16'(2 * k + 1), 8'(k / 2), 8'((k % 2) * 2), k % 2 == 1, k == 5});
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 100 && busy1; i++) tick();
        chk("idle1", busy1, 0);
        tick();
        chk("t4_dones", dones1, 1);
        chk("t4_pops", pops1, 6);
        chk("t4_q", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
